// File: rtl/bot_app_if_if.sv
// Bundle of the application PicoBlaze I/O bus and the BOT system-register signals.
// The master side is the environment (CPU + BOT); the slave side is bot_app_if.
interface bot_app_if_if;
  logic       Wr_Strobe;
  logic       Rd_Strobe;
  logic [7:0] AddrIn;
  logic [7:0] DataIn;
  logic [7:0] DataOut;
  logic       interrupt;
  logic       interrupt_ack;
  logic [7:0] MotCtl;
  logic [7:0] BotConfig;
  logic [7:0] LocX;
  logic [7:0] LocY;
  logic [7:0] BotInfo;
  logic [7:0] Sensors;
  logic       upd_sysregs;

  modport master (
    output Wr_Strobe, Rd_Strobe, AddrIn, DataIn, interrupt_ack,
    output LocX, LocY, BotInfo, Sensors, upd_sysregs,
    input  DataOut, interrupt, MotCtl, BotConfig
  );

  modport slave (
    input  Wr_Strobe, Rd_Strobe, AddrIn, DataIn, interrupt_ack,
    input  LocX, LocY, BotInfo, Sensors, upd_sysregs,
    output DataOut, interrupt, MotCtl, BotConfig
  );
endinterface

// File: rtl/bot_app_if.sv
// Application-side Rojobot register interface: coherent snapshot of BOT registers on
// each update toggle, interrupt handshake, update/miss counters and a motor watchdog.
module bot_app_if #(
  parameter int WDOG_CYCLES = 16
) (
  input logic         clk,
  input logic         reset,
  bot_app_if_if.slave bus
);

  localparam int             WDW    = (WDOG_CYCLES > 0) ? $clog2(WDOG_CYCLES + 1) : 1;
  localparam logic [WDW-1:0] WD_LIM = WDW'(WDOG_CYCLES);
  localparam bit             WD_EN  = (WDOG_CYCLES > 0);

  logic [3:0]     addr;
  logic           upd_d;
  logic           upd_evt;
  logic           miss_evt;
  logic           wr_mot;
  logic           wr_miss;
  logic           wr_cfg;
  logic           wr_stat;
  logic           wd_expire;
  logic [WDW-1:0] wd_cnt;

  logic [7:0] mot_ctl;
  logic [7:0] bot_cfg;
  logic [7:0] shd_x;
  logic [7:0] shd_y;
  logic [7:0] shd_info;
  logic [7:0] shd_sens;
  logic [7:0] upd_cnt;
  logic [7:0] miss_cnt;
  logic [7:0] miss_base;
  logic [7:0] miss_next;
  logic [7:0] rd_data;
  logic [7:0] data_out;
  logic       irq;
  logic       ovf;
  logic       wdog;

  // Reads are side-effect free and only the low nibble of the port address decodes.
  logic unused_bits;
  assign unused_bits = ^{bus.Rd_Strobe, bus.AddrIn[7:4]};

  assign addr     = bus.AddrIn[3:0];
  assign upd_evt  = bus.upd_sysregs ^ upd_d;
  assign miss_evt = upd_evt & irq;

  assign wr_mot  = bus.Wr_Strobe && (addr == 4'd0);
  assign wr_miss = bus.Wr_Strobe && (addr == 4'd6);
  assign wr_cfg  = bus.Wr_Strobe && (addr == 4'd7);
  assign wr_stat = bus.Wr_Strobe && (addr == 4'd8);

  // A MotCtl write landing on the expiry edge takes precedence over the trip.
  assign wd_expire = WD_EN && !wr_mot && (wd_cnt == WD_LIM - WDW'(1));

  always_comb begin
    miss_base = wr_miss ? 8'h00 : miss_cnt;
    miss_next = miss_base;
    if (miss_evt && (miss_base != 8'hFF)) begin
      miss_next = miss_base + 8'd1;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (addr)
      4'd0:    rd_data = mot_ctl;
      4'd1:    rd_data = shd_x;
      4'd2:    rd_data = shd_y;
      4'd3:    rd_data = shd_info;
      4'd4:    rd_data = shd_sens;
      4'd5:    rd_data = upd_cnt;
      4'd6:    rd_data = miss_cnt;
      4'd7:    rd_data = bot_cfg;
      4'd8:    rd_data = {5'b0, ovf, wdog, irq};
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_d    <= 1'b0;
      shd_x    <= 8'h00;
      shd_y    <= 8'h00;
      shd_info <= 8'h00;
      shd_sens <= 8'h00;
      upd_cnt  <= 8'h00;
      miss_cnt <= 8'h00;
      irq      <= 1'b0;
      ovf      <= 1'b0;
      wdog     <= 1'b0;
      mot_ctl  <= 8'h00;
      bot_cfg  <= 8'h00;
      wd_cnt   <= '0;
      data_out <= 8'h00;
    end else begin
      upd_d    <= bus.upd_sysregs;
      data_out <= rd_data;
      miss_cnt <= miss_next;

      if (upd_evt) begin
        shd_x    <= bus.LocX;
        shd_y    <= bus.LocY;
        shd_info <= bus.BotInfo;
        shd_sens <= bus.Sensors;
        upd_cnt  <= upd_cnt + 8'd1;
      end

      if (upd_evt) begin
        irq <= 1'b1;
      end else if (bus.interrupt_ack) begin
        irq <= 1'b0;
      end

      // Status bits: a set on the same edge as a write-1-to-clear wins.
      if (miss_evt) begin
        ovf <= 1'b1;
      end else if (wr_stat && bus.DataIn[2]) begin
        ovf <= 1'b0;
      end

      if (wd_expire) begin
        wdog <= 1'b1;
      end else if (wr_stat && bus.DataIn[1]) begin
        wdog <= 1'b0;
      end

      if (wr_mot) begin
        mot_ctl <= bus.DataIn;
      end else if (wd_expire) begin
        mot_ctl <= 8'h00;
      end

      if (wr_cfg) begin
        bot_cfg <= bus.DataIn;
      end

      // Saturating at the limit makes the trip fire once until the next MotCtl write.
      if (wr_mot) begin
        wd_cnt <= '0;
      end else if (WD_EN && (wd_cnt != WD_LIM)) begin
        wd_cnt <= wd_cnt + WDW'(1);
      end
    end
  end

  assign bus.DataOut   = data_out;
  assign bus.interrupt = irq;
  assign bus.MotCtl    = mot_ctl;
  assign bus.BotConfig = bot_cfg;

endmodule
